// File: rtl/bolme_birimi.sv
// Multi-cycle RV32M divider for the YURUT stage: DIV, DIVU, REM, REMU.
// Radix-2 restoring division, one quotient bit per clock.
module bolme_birimi #(
    parameter int VERI_BIT = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                basla_i,
    input  logic [1:0]          islem_i,
    input  logic [VERI_BIT-1:0] bolunen_i,
    input  logic [VERI_BIT-1:0] bolen_i,
    input  logic                yrt_durdur_i,
    output logic [VERI_BIT-1:0] sonuc_o,
    output logic                hazir_o
);

    localparam int SW = $clog2(VERI_BIT + 1);

    typedef enum logic [1:0] {
        BOS     = 2'd0,
        HESAPLA = 2'd1,
        BITTI   = 2'd2
    } durum_t;

    durum_t durum, durum_sonraki;

    logic [1:0]          islem_r;
    logic                bolunen_isaret;
    logic                bolen_isaret;
    logic [VERI_BIT-1:0] bolum;
    logic [VERI_BIT-1:0] bolen_r;
    logic [VERI_BIT-1:0] kalan;
    logic [SW-1:0]       sayac;

    // Operand conditioning, evaluated only while sitting in BOS.
    logic                isaretli_giris;
    logic [VERI_BIT-1:0] bolunen_mutlak;
    logic [VERI_BIT-1:0] bolen_mutlak;
    logic                sifir_bolen;
    logic                tasma;
    logic                ozel;
    logic [VERI_BIT-1:0] ozel_sonuc;

    assign isaretli_giris = ~islem_i[0];
    assign bolunen_mutlak = (isaretli_giris && bolunen_i[VERI_BIT-1]) ? -bolunen_i : bolunen_i;
    assign bolen_mutlak   = (isaretli_giris && bolen_i[VERI_BIT-1])   ? -bolen_i   : bolen_i;
    assign sifir_bolen    = (bolen_i == '0);
    assign tasma          = isaretli_giris
                            && (bolunen_i == {1'b1, {(VERI_BIT-1){1'b0}}})
                            && (bolen_i == '1);
    assign ozel           = sifir_bolen || tasma;

    always_comb begin
        ozel_sonuc = '0;
        if (sifir_bolen)
            ozel_sonuc = islem_i[1] ? bolunen_i : '1;
        else if (tasma)
            ozel_sonuc = islem_i[1] ? '0 : bolunen_i;
    end

    // One restoring step. The remainder stays below the divisor, so the
    // shifted value fits in VERI_BIT+1 bits and fark's MSB is the borrow.
    logic [VERI_BIT:0]   kaydirilmis;
    logic [VERI_BIT:0]   fark;
    logic [VERI_BIT-1:0] yeni_kalan;
    logic [VERI_BIT-1:0] yeni_bolum;
    logic                isaretli_r;
    logic [VERI_BIT-1:0] duz_bolum;
    logic [VERI_BIT-1:0] duz_kalan;
    logic                son_sayac;

    assign kaydirilmis = {kalan, bolum[VERI_BIT-1]};
    assign fark        = kaydirilmis - {1'b0, bolen_r};
    assign yeni_kalan  = fark[VERI_BIT] ? kaydirilmis[VERI_BIT-1:0] : fark[VERI_BIT-1:0];
    assign yeni_bolum  = {bolum[VERI_BIT-2:0], ~fark[VERI_BIT]};
    assign isaretli_r  = ~islem_r[0];
    assign duz_bolum   = (isaretli_r && (bolunen_isaret ^ bolen_isaret)) ? -yeni_bolum : yeni_bolum;
    assign duz_kalan   = (isaretli_r && bolunen_isaret) ? -yeni_kalan : yeni_kalan;
    assign son_sayac   = (sayac == SW'(VERI_BIT - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            durum <= BOS;
        else
            durum <= durum_sonraki;
    end

    always_comb begin
        durum_sonraki = durum;
        hazir_o       = 1'b1;
        case (durum)
            BOS: begin
                hazir_o = ~basla_i;
                if (basla_i)
                    durum_sonraki = ozel ? BITTI : HESAPLA;
            end
            HESAPLA: begin
                hazir_o = 1'b0;
                if (son_sayac)
                    durum_sonraki = BITTI;
            end
            BITTI: begin
                if (!yrt_durdur_i)
                    durum_sonraki = BOS;
            end
            default: durum_sonraki = BOS;
        endcase
        if (rst_i)
            hazir_o = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            islem_r        <= '0;
            bolunen_isaret <= 1'b0;
            bolen_isaret   <= 1'b0;
            bolum          <= '0;
            bolen_r        <= '0;
            kalan          <= '0;
            sayac          <= '0;
            sonuc_o        <= '0;
        end else begin
            case (durum)
                BOS: begin
                    if (basla_i) begin
                        islem_r        <= islem_i;
                        bolunen_isaret <= bolunen_i[VERI_BIT-1];
                        bolen_isaret   <= bolen_i[VERI_BIT-1];
                        bolum          <= bolunen_mutlak;
                        bolen_r        <= bolen_mutlak;
                        kalan          <= '0;
                        sayac          <= '0;
                        if (ozel)
                            sonuc_o <= ozel_sonuc;
                    end
                end
                HESAPLA: begin
                    kalan <= yeni_kalan;
                    bolum <= yeni_bolum;
                    sayac <= sayac + 1'b1;
                    if (son_sayac)
                        sonuc_o <= islem_r[1] ? duz_kalan : duz_bolum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bolme_birimi.sv
// Directed bench for bolme_birimi: latency, sign rules, special cases,
// result hold under stall and asynchronous reset mid-division.
module tb_bolme_birimi;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [1:0] S_BOS     = 2'd0;
    localparam logic [1:0] S_HESAPLA = 2'd1;
    localparam logic [1:0] S_BITTI   = 2'd2;

    logic        clk_i;
    logic        rst_i;
    logic        basla_i;
    logic [1:0]  islem_i;
    logic [31:0] bolunen_i;
    logic [31:0] bolen_i;
    logic        yrt_durdur_i;
    logic [31:0] sonuc_o;
    logic        hazir_o;

    int checks = 0;
    int errors = 0;

    bolme_birimi #(.VERI_BIT(32)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .basla_i      (basla_i),
        .islem_i      (islem_i),
        .bolunen_i    (bolunen_i),
        .bolen_i      (bolen_i),
        .yrt_durdur_i (yrt_durdur_i),
        .sonuc_o      (sonuc_o),
        .hazir_o      (hazir_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tik();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_durum(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s state observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one divide, count the cycles hazir_o stays low, check the
    // result in BITTI, then retire the instruction and confirm BOS.
    task automatic do_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_low);
        int n;
        basla_i   = 1'b1;
        islem_i   = op;
        bolunen_i = a;
        bolen_i   = b;
        #1;
        n = 0;
        while (hazir_o === 1'b0 && n < 200) begin
            n++;
            tik();
        end
        chk_int({tag, "_stall"}, n, exp_low);
        chk32({tag, "_sonuc"}, sonuc_o, exp);
        chk_durum({tag, "_bitti"}, dut.durum, S_BITTI);
        tik();
        basla_i = 1'b0;
        #1;
        chk_durum({tag, "_bos"}, dut.durum, S_BOS);
        chk1({tag, "_hazir_bos"}, hazir_o, 1'b1);
    endtask

    initial begin
        rst_i        = 1'b1;
        basla_i      = 1'b1;
        islem_i      = OP_DIV;
        bolunen_i    = 32'd0;
        bolen_i      = 32'd0;
        yrt_durdur_i = 1'b0;

        #12;
        chk1("reset_hazir", hazir_o, 1'b1);
        chk32("reset_sonuc", sonuc_o, 32'h0);
        chk_durum("reset_durum", dut.durum, S_BOS);
        basla_i = 1'b0;
        #1;
        rst_i = 1'b0;
        tik();

        // Basic signed divide, full latency
        do_div("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd14, 33);

        // Sign rules
        do_div("rem_m100_7", OP_REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 33);
        do_div("div_m100_7", OP_DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33);
        do_div("divu_ff_2", OP_DIVU, 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 33);
        do_div("remu_ff_2", OP_REMU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 33);
        do_div("div_100_m7", OP_DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33);
        do_div("rem_100_m7", OP_REM, 32'd100, 32'hFFFFFFF9, 32'h00000002, 33);

        // Divide by zero
        do_div("div_zero", OP_DIV, 32'h12345678, 32'd0, 32'hFFFFFFFF, 1);
        do_div("rem_zero", OP_REM, 32'h12345678, 32'd0, 32'h12345678, 1);
        do_div("divu_zero", OP_DIVU, 32'h12345678, 32'd0, 32'hFFFFFFFF, 1);
        do_div("remu_zero", OP_REMU, 32'h12345678, 32'd0, 32'h12345678, 1);

        // Signed overflow; the unsigned form of the same operands is ordinary
        do_div("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
        do_div("rem_ovf", OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
        do_div("divu_big", OP_DIVU, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);

        // Hold in BITTI under stall with basla_i still high
        yrt_durdur_i = 1'b1;
        basla_i      = 1'b1;
        islem_i      = OP_DIV;
        bolunen_i    = 32'd100;
        bolen_i      = 32'd7;
        #1;
        for (int i = 0; i < 200 && hazir_o === 1'b0; i++) tik();
        chk32("hold_first", sonuc_o, 32'd14);
        for (int i = 0; i < 3; i++) begin
            tik();
            chk32("hold_sonuc", sonuc_o, 32'd14);
            chk1("hold_hazir", hazir_o, 1'b1);
            chk_durum("hold_durum", dut.durum, S_BITTI);
        end
        yrt_durdur_i = 1'b0;
        tik();
        chk_durum("release_bos", dut.durum, S_BOS);
        chk1("release_hazir_low", hazir_o, 1'b0);
        do_div("b2b_96_8", OP_DIV, 32'd96, 32'd8, 32'd12, 33);

        // Asynchronous reset in the middle of HESAPLA
        basla_i   = 1'b1;
        islem_i   = OP_DIVU;
        bolunen_i = 32'd1000;
        bolen_i   = 32'd3;
        tik();
        for (int i = 1; i < 10; i++) tik();
        chk_durum("pre_reset_hesapla", dut.durum, S_HESAPLA);
        chk1("pre_reset_hazir", hazir_o, 1'b0);
        #2;
        rst_i = 1'b1;
        #1;
        chk32("midrst_sonuc", sonuc_o, 32'h0);
        chk1("midrst_hazir", hazir_o, 1'b1);
        chk_durum("midrst_durum", dut.durum, S_BOS);
        basla_i = 1'b0;
        #1;
        rst_i = 1'b0;
        tik();
        do_div("after_rst_9_3", OP_DIV, 32'd9, 32'd3, 32'd3, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
